// File: rtl/rf_pkg.sv
// Shared types and defaults for the 2-read / 1-write register file.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  function automatic int rf_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Decode/write-back facing bus of the register file: two read ports, one write port, ready.
interface reg_file_2r1w_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic              ready;

  modport master (
    output readReg1, readReg2, writeReg, writeData, regWrite,
    input  readData1, readData2, ready
  );

  modport slave (
    input  readReg1, readReg2, writeReg, writeData, regWrite,
    output readData1, readData2, ready
  );

endinterface

// File: rtl/rf_clear_ctrl.sv
// Clear sequencer: after reset walks every entry once, writing zero, then enters RUN.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              run,
  output logic              ready
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clear_we   = 1'b0;
    clear_addr = idx_q;
    run        = (state_q == RUN);
    ready      = (state_q == RUN);
    if (state_q == CLEAR) begin
      // A held reset must not advance or write; the flop reset restarts at idx 0.
      clear_we = !rst;
      idx_d    = idx_q + ADDR_W'(1);
      if (idx_q == {ADDR_W{1'b1}}) begin
        state_d = RUN;
      end
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised 2R/1W register file with hardwired-zero option and reset clear sequence.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_2r1w_if.slave rf
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] bank_q [DEPTH];

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              run;
  logic              ready;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  rf_clear_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clear_we  (clear_we),
    .clear_addr(clear_addr),
    .run       (run),
    .ready     (ready)
  );

  // The sequencer owns the write port until RUN; bus writes during CLEAR are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clear_addr;
    wr_data = '0;
    if (!run) begin
      wr_en = clear_we;
    end else if (rf.regWrite && !(ZERO_REG && rf.writeReg == '0)) begin
      wr_en   = 1'b1;
      wr_addr = rf.writeReg;
      wr_data = rf.writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  assign rd_addr[0] = rf.readReg1;
  assign rd_addr[1] = rf.readReg2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = bank_q[rd_addr[p]];
`ifdef RF_BYPASS_EN
      if (run && rf.regWrite && rf.writeReg == rd_addr[p]) begin
        rd_data[p] = rf.writeData;
      end
`endif
      // Zero-register and CLEAR masking take priority over any forwarded value.
      if (!run || (ZERO_REG && rd_addr[p] == '0)) begin
        rd_data[p] = '0;
      end
    end
  end

  assign rf.readData1 = rd_data[0];
  assign rf.readData2 = rd_data[1];
  assign rf.ready     = ready;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w with a per-cycle array model and literal spot checks.
module tb_reg_file_2r1w;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_2r1w_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

  reg_file_2r1w #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rf (rf_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: an array, a count of clear edges since the last reset, and the spec's rules.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt     = 0;
  bit            m_started = 1'b0;
  wire           m_ready   = m_started && (m_cnt == DEPTH);

  always @(posedge clk) begin
    if (m_ready && rf_if.regWrite && rf_if.writeReg != 0)
      m_mem[rf_if.writeReg] <= rf_if.writeData;
    if (rst) begin
      m_cnt     <= 0;
      m_started <= 1'b1;
    end else if (m_started && m_cnt < DEPTH) begin
      m_mem[m_cnt] <= '0;
      m_cnt        <= m_cnt + 1;
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (rf_if.regWrite && rf_if.writeReg == a) return rf_if.writeData;
`endif
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_started) begin
      check("model_ready", {31'd0, rf_if.ready}, {31'd0, m_ready});
      check("model_rd1", rf_if.readData1, exp_read(rf_if.readReg1));
      check("model_rd2", rf_if.readData2, exp_read(rf_if.readReg2));
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rf_if.regWrite  = 1'b1;
    rf_if.writeReg  = a;
    rf_if.writeData = d;
    @(posedge clk); #1;
    rf_if.regWrite  = 1'b0;
  endtask

  logic [DW-1:0] hazard_exp;

  initial begin
    rst             = 1'b1;
    rf_if.regWrite  = 1'b0;
    rf_if.writeReg  = '0;
    rf_if.writeData = '0;
    rf_if.readReg1  = 5'd5;
    rf_if.readReg2  = 5'd31;

    // First reset: probe 5 and 31 through the clear, ready exactly 32 edges later.
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, rf_if.ready}, 32'd0);
    check("rst_rd5", rf_if.readData1, 32'd0);
    check("rst_rd31", rf_if.readData2, 32'd0);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      check("clear1_ready", {31'd0, rf_if.ready}, (k == DEPTH) ? 32'd1 : 32'd0);
      if (k < DEPTH) check("clear1_rd5", rf_if.readData1, 32'd0);
    end

    // Basic write/read.
    do_write(5'd7, 32'hDEADBEEF);
    rf_if.readReg1 = 5'd7;
    rf_if.readReg2 = 5'd8;
    #1;
    check("wr_r7", rf_if.readData1, 32'hDEADBEEF);
    check("wr_r8", rf_if.readData2, 32'd0);

    do_write(5'd3, 32'h0000_0077);
    rf_if.readReg1 = 5'd3;
    #1;
    check("wr_r3", rf_if.readData1, 32'h0000_0077);

    // Zero register ignores writes.
    do_write(5'd0, 32'h12345678);
    rf_if.readReg1 = 5'd0;
    rf_if.readReg2 = 5'd7;
    #1;
    check("zero_r0", rf_if.readData1, 32'd0);
    check("zero_r7", rf_if.readData2, 32'hDEADBEEF);

    // Same-cycle write/read hazard on r9.
    do_write(5'd9, 32'h1);
`ifdef RF_BYPASS_EN
    hazard_exp = 32'hAA;
`else
    hazard_exp = 32'h1;
`endif
    rf_if.regWrite  = 1'b1;
    rf_if.writeReg  = 5'd9;
    rf_if.writeData = 32'hAA;
    rf_if.readReg1  = 5'd9;
    rf_if.readReg2  = 5'd9;
    #1;
    check("hazard_rd1", rf_if.readData1, hazard_exp);
    check("hazard_rd2", rf_if.readData2, hazard_exp);
    @(posedge clk); #1;
    rf_if.regWrite = 1'b0;
    #1;
    check("hazard_next_rd1", rf_if.readData1, 32'hAA);
    check("hazard_next_rd2", rf_if.readData2, 32'hAA);

    // Second reset with a write attempt at clear cycle 10 and a restart at cycle 20.
    rf_if.readReg1 = 5'd3;
    rf_if.readReg2 = 5'd7;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      rf_if.regWrite = 1'b0;
      if (k == 10) begin
        rf_if.regWrite  = 1'b1;
        rf_if.writeReg  = 5'd3;
        rf_if.writeData = 32'h55;
      end
      check("clear2_ready", {31'd0, rf_if.ready}, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk); #1;
      check("clear3_ready", {31'd0, rf_if.ready}, (k == DEPTH) ? 32'd1 : 32'd0);
    end
    #1;
    check("after_clear_r3", rf_if.readData1, 32'd0);
    check("after_clear_r7", rf_if.readData2, 32'd0);
    rf_if.readReg1 = 5'd9;
    #1;
    check("after_clear_r9", rf_if.readData1, 32'd0);

    do_write(5'd31, 32'hCAFE_F00D);
    rf_if.readReg2 = 5'd31;
    #1;
    check("wr_r31", rf_if.readData2, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised two-read / one-write register file for the CPU datapath, replacing the fixed 32x32 bank. It adds a real clock edge for writes, a hardwired-zero register option, and a reset-driven clear sequencer that zeroes every entry and signals readiness to the pipeline. Optional same-cycle write-to-read forwarding is selectable at compile time. The block sits between decode (read ports) and write-back (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- readReg1  in  ADDR_W  read port 1 address
- readReg2  in  ADDR_W  read port 2 address
- readData1  out  DATA_W  read port 1 data (combinational from array)
- readData2  out  DATA_W  read port 2 data
- writeReg  in  ADDR_W  write address
- writeData  in  DATA_W  write data
- regWrite  in  1  write enable, sampled on clk rising edge
- ready  out  1  high once the clear sequence has completed; writes accepted only when high

## Operation
- States: CLEAR, RUN. A sampled rst forces CLEAR with clear index idx=0. rst does not touch the array directly.
- CLEAR, rst low: Bank[idx] <= 0, idx <= idx+1. When idx==DEPTH-1, the last entry is written and the next state is RUN.
- CLEAR: regWrite is ignored. readData1/2 are forced to 0 regardless of address.
- RUN: if regWrite and not (ZERO_REG and writeReg==0), then Bank[writeReg] <= writeData at the edge.
- Reads in RUN: readDataN = Bank[readRegN]. If ZERO_REG and readRegN==0, the read returns 0.
- Both read ports may address the same entry, and either or both may equal writeReg.
- All widths are exact. There is no truncation or extension; addresses cover the full DEPTH.

## Timing
- Reset values: ready=0, state=CLEAR, idx=0. readData1/2 are 0 throughout CLEAR.
- rst is asserted at edge E0 and released before E1. Clear writes occur at edges E1..E_DEPTH. ready rises after edge E_DEPTH (32 cycles for default).
- rst reasserted mid-clear restarts the sequence at idx=0. rst in RUN drops ready at the next edge.
- Write latency: a write at edge E is visible on reads combinationally after E.
- Read latency: 0 cycles. This is combinational from address to data.
- A write and a read to the same address in the same cycle returns the old value unless bypass is compiled in (see Configuration).

## Configuration
- RF_BYPASS_EN defined: in RUN, if regWrite and writeReg==readRegN and the address is not the zero register under ZERO_REG, then readDataN = writeData in the same cycle. The array update is unchanged.
- RF_BYPASS_EN undefined: no forwarding. A same-cycle read returns the pre-write contents.
- Neither setting affects CLEAR behaviour or the zero-register rule.

## Structure
- Package rf_pkg holds:
  - the state typedef (CLEAR, RUN)
  - default DATA_W / ADDR_W constants
  - the DEPTH derivation helper
- Sub-module rf_clear_ctrl holds:
  - the CLEAR/RUN FSM, idx counter and ready
  - outputs: clear_we, clear_addr and run. The top level muxes these onto the array write port.
- The top level holds the array, the read muxes, zero-register masking and the optional bypass.

## Test plan
- Reset and clear: pulse rst for 1 cycle, then probe reads at addresses 5 and 31 each cycle. Both must read 0, and ready must rise exactly 32 edges after rst release.
- Basic write/read: in RUN write 0xDEADBEEF to r7. Next cycle readReg1=7 -> 0xDEADBEEF, and readReg2=8 -> 0.
- Zero register: with ZERO_REG=1 write 0x12345678 to r0. Next cycle readData1 for r0 -> 0.
- Same-cycle hazard: with r9=0x1 write 0xAA to r9 while reading r9 on both ports. Required result: 0xAA with RF_BYPASS_EN, 0x1 without; 0xAA on the next cycle in both builds.
- Write during clear: assert regWrite r3=0x55 at cycle 10 of CLEAR. After ready, r3 must read 0.
- Reset mid-clear: reassert rst at clear cycle 20. ready must rise 32 edges after the second release, not earlier.
